// File: rtl/cmd_frame_pkg.sv
// Shared constants, state encoding and opcode table for the Ethernet command frame parser.
package cmd_frame_pkg;

  localparam int OFS_SRC_MAC = 6;
  localparam int OFS_OPCODE  = 16;
  localparam int OFS_ID      = 20;
  localparam int OFS_PAYLOAD = 24;

  localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

  localparam logic [31:0] OP_FFWW = 32'h4646_5757;
  localparam logic [31:0] OP_CCWW = 32'h4343_5757;
  localparam logic [31:0] OP_FFRR = 32'h4646_5252;
  localparam logic [31:0] OP_CCRR = 32'h4343_5252;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_TAIL    = 3'd2,
    ST_DROP    = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  function automatic logic is_known_opcode(input logic [31:0] op);
    return (op == OP_FFWW) || (op == OP_CCWW) || (op == OP_FFRR) || (op == OP_CCRR);
  endfunction

  // Byte idx of a MAC address as it appears on the wire (first byte = MSB).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [7:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      8'd0:    b = mac[47:40];
      8'd1:    b = mac[39:32];
      8'd2:    b = mac[31:24];
      8'd3:    b = mac[23:16];
      8'd4:    b = mac[15:8];
      8'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cmd_stat_counter.sv
// Saturating statistics counter with synchronous active-high reset.
module cmd_stat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cmd_frame_parser.sv
// Filters a byte-wide AXI-Stream of Ethernet frames on destination MAC and
// presents each good command (opcode, id, payload) on a valid/ready output.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 12,
  parameter logic [47:0] FPGA_MAC      = 48'h5a01_0203_0405,
  parameter bit          ACCEPT_BCAST  = 1'b1,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                       gtx_clk_bufg,
  input  logic                       gtx_reset,
  input  logic [7:0]                 rx_axis_tdata,
  input  logic                       rx_axis_tvalid,
  input  logic                       rx_axis_tlast,
  input  logic                       rx_axis_tuser,
  output logic                       rx_axis_tready,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [31:0]                cmd_opcode,
  output logic [31:0]                cmd_id,
  output logic [8*PAYLOAD_BYTES-1:0] cmd_payload,
  output logic [47:0]                cmd_src_mac,
  output logic                       cmd_known,
  output logic [CNT_WIDTH-1:0]       frame_ok_cnt,
  output logic [CNT_WIDTH-1:0]       frame_drop_cnt,
  output logic [CNT_WIDTH-1:0]       frame_err_cnt,
  output logic [2:0]                 dbg_state
);

  localparam int          PL_W         = 8 * PAYLOAD_BYTES;
  localparam logic [7:0]  IDX_HDR_LAST = 8'(OFS_PAYLOAD - 1);
  localparam logic [7:0]  IDX_PL_LAST  = 8'(OFS_PAYLOAD + PAYLOAD_BYTES - 1);

  state_e            r_state;
  state_e            w_state_nx;
  logic [7:0]        r_idx;
  logic              r_uni_ok;
  logic              r_bc_ok;
  logic [47:0]       r_sh_src;
  logic [31:0]       r_sh_op;
  logic [31:0]       r_sh_id;
  logic [PL_W-1:0]   r_sh_pl;
  logic [PL_W-1:0]   w_sh_pl_nx;
  logic [7:0]        w_pl_ofs;

  logic [31:0]       r_cmd_opcode;
  logic [31:0]       r_cmd_id;
  logic [PL_W-1:0]   r_cmd_payload;
  logic [47:0]       r_cmd_src_mac;
  logic              r_cmd_known;

  logic w_beat, w_end, w_parse, w_in_mac, w_uni_nx, w_bc_nx, w_mac_fail;
  logic w_short, w_drop_inc, w_err_inc, w_commit, w_known;

  // Handshakes: an RX byte moves when tvalid && tready at a clock edge; a command
  // moves when cmd_valid && cmd_ready. Both producers hold their data until taken.
  assign rx_axis_tready = !gtx_reset && (r_state != ST_HOLD);
  assign cmd_valid      = (r_state == ST_HOLD);
  assign dbg_state      = r_state;

  assign w_beat     = rx_axis_tvalid && rx_axis_tready;
  assign w_end      = w_beat && rx_axis_tlast;
  assign w_parse    = (r_state == ST_HDR) || (r_state == ST_PAYLOAD) || (r_state == ST_TAIL);
  assign w_in_mac   = (r_state == ST_HDR) && (r_idx < 8'd6);
  assign w_uni_nx   = r_uni_ok && (rx_axis_tdata == mac_byte(FPGA_MAC, r_idx));
  assign w_bc_nx    = ACCEPT_BCAST && r_bc_ok && (rx_axis_tdata == mac_byte(BCAST_MAC, r_idx));
  assign w_mac_fail = w_in_mac && !w_uni_nx && !w_bc_nx;
  assign w_short    = r_idx < IDX_PL_LAST;
  // A MAC failure on the tlast beat is always a short frame, so it lands in drop only.
  assign w_drop_inc = w_end && ((r_state == ST_DROP) || (w_parse && w_short));
  assign w_err_inc  = w_end && w_parse && !w_short && rx_axis_tuser;
  assign w_commit   = w_end && w_parse && !w_short && !rx_axis_tuser;
  assign w_known    = is_known_opcode(r_sh_op);
  assign w_pl_ofs   = r_idx - 8'(OFS_PAYLOAD);

  // Payload shadow including the current byte, so a tlast on the final payload
  // byte commits a complete payload.
  always_comb begin
    w_sh_pl_nx = r_sh_pl;
    if (w_beat && (r_state == ST_PAYLOAD)) begin
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        if (w_pl_ofs == 8'(k)) w_sh_pl_nx[8*k +: 8] = rx_axis_tdata;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_HDR: begin
        if (w_beat && !rx_axis_tlast) begin
          if (w_mac_fail)                  w_state_nx = ST_DROP;
          else if (r_idx == IDX_HDR_LAST)  w_state_nx = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_beat && !rx_axis_tlast && (r_idx == IDX_PL_LAST)) w_state_nx = ST_TAIL;
      end
      ST_TAIL, ST_DROP: w_state_nx = r_state;
      ST_HOLD: begin
        if (cmd_ready) w_state_nx = ST_HDR;
      end
      default: w_state_nx = ST_HDR;
    endcase
    if (w_end) w_state_nx = w_commit ? ST_HOLD : ST_HDR;
  end

  always_ff @(posedge gtx_clk_bufg) begin
    if (gtx_reset) begin
      r_state       <= ST_HDR;
      r_idx         <= 8'd0;
      r_uni_ok      <= 1'b1;
      r_bc_ok       <= 1'b1;
      r_sh_src      <= '0;
      r_sh_op       <= '0;
      r_sh_id       <= '0;
      r_sh_pl       <= '0;
      r_cmd_opcode  <= '0;
      r_cmd_id      <= '0;
      r_cmd_payload <= '0;
      r_cmd_src_mac <= '0;
      r_cmd_known   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sh_pl <= w_sh_pl_nx;
      if (w_beat) begin
        if (rx_axis_tlast) begin
          r_idx    <= 8'd0;
          r_uni_ok <= 1'b1;
          r_bc_ok  <= 1'b1;
        end else begin
          if (r_idx != 8'hff) r_idx <= r_idx + 8'd1;
          if (w_in_mac) begin
            r_uni_ok <= w_uni_nx;
            r_bc_ok  <= w_bc_nx;
          end
        end
        if (r_state == ST_HDR) begin
          if ((r_idx >= 8'(OFS_SRC_MAC)) && (r_idx < 8'(OFS_SRC_MAC + 6)))
            r_sh_src <= {r_sh_src[39:0], rx_axis_tdata};
          if ((r_idx >= 8'(OFS_OPCODE)) && (r_idx < 8'(OFS_OPCODE + 4)))
            r_sh_op <= {r_sh_op[23:0], rx_axis_tdata};
          // Id arrives little-endian: shift in from the top.
          if ((r_idx >= 8'(OFS_ID)) && (r_idx < 8'(OFS_ID + 4)))
            r_sh_id <= {rx_axis_tdata, r_sh_id[31:8]};
        end
      end
      if (w_commit) begin
        r_cmd_opcode  <= r_sh_op;
        r_cmd_id      <= r_sh_id;
        r_cmd_payload <= w_sh_pl_nx;
        r_cmd_src_mac <= r_sh_src;
        r_cmd_known   <= w_known;
      end
    end
  end

  assign cmd_opcode  = r_cmd_opcode;
  assign cmd_id      = r_cmd_id;
  assign cmd_payload = r_cmd_payload;
  assign cmd_src_mac = r_cmd_src_mac;
  assign cmd_known   = r_cmd_known;

  cmd_stat_counter #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
    .i_clk (gtx_clk_bufg),
    .i_rst (gtx_reset),
    .i_inc (w_commit),
    .o_cnt (frame_ok_cnt)
  );

  cmd_stat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .i_clk (gtx_clk_bufg),
    .i_rst (gtx_reset),
    .i_inc (w_drop_inc),
    .o_cnt (frame_drop_cnt)
  );

  cmd_stat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .i_clk (gtx_clk_bufg),
    .i_rst (gtx_reset),
    .i_inc (w_err_inc),
    .o_cnt (frame_err_cnt)
  );

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser with hand-computed expectations.
module tb_cmd_frame_parser;
  import cmd_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, tready;
  logic        cmd_valid, cmd_ready, cmd_known;
  logic [31:0] cmd_opcode, cmd_id;
  logic [95:0] cmd_payload;
  logic [47:0] cmd_src_mac;
  logic [15:0] ok_cnt, drop_cnt, err_cnt;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int max_wait;
  int bad;
  logic [7:0] frm [0:47];

  localparam logic [95:0] EXP_PL  = 96'h00000077_00000004_0000001e;
  localparam logic [47:0] EXP_SRC = 48'ha45e60ee9f35;
  localparam logic [47:0] MY_MAC  = 48'h5a0102030405;

  always #5 clk = ~clk;

  cmd_frame_parser dut (
    .gtx_clk_bufg   (clk),
    .gtx_reset      (rst),
    .rx_axis_tdata  (tdata),
    .rx_axis_tvalid (tvalid),
    .rx_axis_tlast  (tlast),
    .rx_axis_tuser  (tuser),
    .rx_axis_tready (tready),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_id         (cmd_id),
    .cmd_payload    (cmd_payload),
    .cmd_src_mac    (cmd_src_mac),
    .cmd_known      (cmd_known),
    .frame_ok_cnt   (ok_cnt),
    .frame_drop_cnt (drop_cnt),
    .frame_err_cnt  (err_cnt),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [31:0] opc, input logic [31:0] cid);
    logic [47:0] s;
    logic [95:0] p;
    s = EXP_SRC;
    p = EXP_PL;
    for (int i = 0; i < 6; i++) begin
      frm[i]     = dst[8*(5-i) +: 8];
      frm[6 + i] = s[8*(5-i) +: 8];
    end
    frm[12] = 8'h00; frm[13] = 8'h22; frm[14] = 8'h02; frm[15] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      frm[16 + i] = opc[8*(3-i) +: 8];
      frm[20 + i] = cid[8*i +: 8];
    end
    for (int i = 0; i < 12; i++) frm[24 + i] = p[8*i +: 8];
    for (int i = 36; i < 48; i++) frm[i] = 8'(i);
  endtask

  // Called at a negedge; each byte is presented until tready is seen, then
  // transfers on the following posedge.
  task automatic send_range(input int from, input int to, input bit do_last, input bit user);
    int n;
    for (int i = from; i <= to; i++) begin
      tdata  = frm[i];
      tvalid = 1'b1;
      tlast  = do_last && (i == to);
      tuser  = do_last && (i == to) && user;
      n = 0;
      while (tready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n > max_wait) max_wait = n;
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout byte=%0d tready=%b expected=1", i, tready);
      end
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("valid_after_ack", cmd_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; cmd_ready = 1'b0;
    max_wait = 0;
    @(negedge clk);
    @(negedge clk);
    check("tready_in_reset", tready, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_ok", ok_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_opcode", cmd_opcode, 0);
    check("rst_state", dbg_state, 128'(ST_HDR));
    rst = 1'b0;
    #1;
    check("tready_after_reset", tready, 1);
    @(negedge clk);

    // Good frame
    build(MY_MAC, OP_FFWW, 32'h000017fc);
    send_range(0, 47, 1'b1, 1'b0);
    check("good_valid", cmd_valid, 1);
    check("good_state", dbg_state, 128'(ST_HOLD));
    check("good_opcode", cmd_opcode, 32'h46465757);
    check("good_id", cmd_id, 32'h000017fc);
    check("good_payload", cmd_payload, 96'h00000077_00000004_0000001e);
    check("good_src", cmd_src_mac, 48'ha45e60ee9f35);
    check("good_known", cmd_known, 1);
    check("good_ok_cnt", ok_cnt, 1);
    check("good_tready_hold", tready, 0);
    repeat (3) @(negedge clk);
    check("hold_valid_stable", cmd_valid, 1);
    check("hold_id_stable", cmd_id, 32'h000017fc);
    accept();
    check("opcode_held_after_ack", cmd_opcode, 32'h46465757);

    // Wrong destination
    build(48'h5a0102030406, OP_FFWW, 32'h00000050);
    max_wait = 0;
    send_range(0, 47, 1'b1, 1'b0);
    check("drop_tready_high", max_wait, 0);
    check("drop_valid", cmd_valid, 0);
    check("drop_cnt1", drop_cnt, 1);
    check("drop_ok_unchanged", ok_cnt, 1);

    // Short frame, then a good one
    build(MY_MAC, OP_FFWW, 32'h00000100);
    send_range(0, 30, 1'b1, 1'b0);
    check("short_valid", cmd_valid, 0);
    check("short_drop_cnt", drop_cnt, 2);
    send_range(0, 47, 1'b1, 1'b0);
    check("after_short_valid", cmd_valid, 1);
    check("after_short_id", cmd_id, 32'h00000100);
    check("after_short_ok", ok_cnt, 2);
    accept();

    // Errored frame
    build(MY_MAC, OP_FFWW, 32'h00000180);
    send_range(0, 47, 1'b1, 1'b1);
    check("tuser_valid", cmd_valid, 0);
    check("tuser_err_cnt", err_cnt, 1);
    check("tuser_ok_cnt", ok_cnt, 2);

    // Backpressure with a second frame queued
    build(MY_MAC, OP_FFWW, 32'h00000200);
    send_range(0, 47, 1'b1, 1'b0);
    check("bp_first_ok", ok_cnt, 3);
    build(MY_MAC, OP_FFWW, 32'h00000201);
    tdata = frm[0];
    tvalid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tready !== 1'b0) bad++;
    end
    check("bp_tready_low", bad, 0);
    check("bp_valid_held", cmd_valid, 1);
    check("bp_id_held", cmd_id, 32'h00000200);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("bp_released_valid", cmd_valid, 0);
    send_range(0, 47, 1'b1, 1'b0);
    check("bp_second_valid", cmd_valid, 1);
    check("bp_second_id", cmd_id, 32'h00000201);
    check("bp_second_ok", ok_cnt, 4);
    accept();

    // Opcode table
    build(MY_MAC, OP_CCWW, 32'h00000300);
    send_range(0, 47, 1'b1, 1'b0);
    check("ccww_known", cmd_known, 1);
    check("ccww_opcode", cmd_opcode, 32'h43435757);
    accept();
    build(MY_MAC, 32'h41424344, 32'h00000301);
    send_range(0, 47, 1'b1, 1'b0);
    check("unknown_valid", cmd_valid, 1);
    check("unknown_known", cmd_known, 0);
    check("unknown_opcode", cmd_opcode, 32'h41424344);
    check("unknown_ok", ok_cnt, 6);
    accept();

    // Broadcast destination
    build(48'hffffffffffff, OP_FFRR, 32'h00000400);
    send_range(0, 47, 1'b1, 1'b0);
    check("bcast_valid", cmd_valid, 1);
    check("bcast_known", cmd_known, 1);
    check("bcast_id", cmd_id, 32'h00000400);
    accept();

    // Mixed unicast/broadcast bytes must not match
    build(48'h5a0102ffffff, OP_FFWW, 32'h00000450);
    send_range(0, 47, 1'b1, 1'b0);
    check("mixed_mac_valid", cmd_valid, 0);
    check("mixed_mac_drop", drop_cnt, 3);

    // tlast one byte before and exactly on the last payload byte
    build(MY_MAC, OP_FFWW, 32'h00000500);
    send_range(0, 34, 1'b1, 1'b0);
    check("len35_valid", cmd_valid, 0);
    check("len35_drop", drop_cnt, 4);
    send_range(0, 35, 1'b1, 1'b0);
    check("len36_valid", cmd_valid, 1);
    check("len36_payload", cmd_payload, 96'h00000077_00000004_0000001e);
    check("len36_ok", ok_cnt, 8);
    accept();

    // Reset mid-frame at b=10
    build(MY_MAC, OP_FFWW, 32'h00000600);
    send_range(0, 9, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_tready", tready, 0);
    @(negedge clk);
    check("midrst_ok", ok_cnt, 0);
    check("midrst_drop", drop_cnt, 0);
    check("midrst_err", err_cnt, 0);
    check("midrst_opcode", cmd_opcode, 0);
    check("midrst_id", cmd_id, 0);
    check("midrst_payload", cmd_payload, 0);
    check("midrst_src", cmd_src_mac, 0);
    check("midrst_known", cmd_known, 0);
    check("midrst_state", dbg_state, 128'(ST_HDR));
    rst = 1'b0;
    #1;
    check("midrst_tready_after", tready, 1);
    send_range(10, 47, 1'b1, 1'b0);
    check("remainder_valid", cmd_valid, 0);
    check("remainder_drop", drop_cnt, 1);
    check("remainder_ok", ok_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
